// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   start  - request strobe (sampled only while busy=0)
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b   - rs / rt operands
//   cancel - pipeline flush, aborts an in-flight operation
//   busy   - operation iterating, hazard unit stalls on this
//   done   - one-cycle pulse when HI/LO were written by a mul/div
//   hi, lo - architectural HI/LO registers
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO, also
// serving MTHI/MTLO. One radix-2 step per clock, 32 steps, then a sign-fix
// cycle that writes HI/LO.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mul_div_unit_if.slave (start/op/a/b/cancel in, busy/done/hi/lo out)
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  // Mul: {partial product upper, multiplier being shifted out}.
  // Div: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic               is_div;
  logic               neg_main;  // negate product, or negate quotient
  logic               neg_rem;   // remainder takes the dividend's sign

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Request decode
  logic               req_muldiv;
  logic               req_signed;
  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign req_muldiv = (bus.op[2] == 1'b0);
  assign req_signed = (bus.op[0] == 1'b0);
  assign accept     = (state == IDLE) && bus.start && !bus.cancel;
  assign mag_a      = (req_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b      = (req_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step; the borrow bit of the trial subtraction
  // tells whether the shifted remainder was below the divisor.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  // Sign correction. A zero divisor needs no special case: every trial
  // subtraction succeeds, so the quotient is all ones and the remainder ends
  // up as |a|, which the dividend-sign fix turns back into a.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_main ? -acc : acc;
  assign quo_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && req_muldiv) state_nx = CALC;
      CALC: begin
        if (bus.cancel)        state_nx = IDLE;
        else if (cnt == LAST)  state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && req_muldiv) begin
            cnt    <= '0;
            is_div <= bus.op[1];
            if (bus.op[1]) begin
              acc      <= {{WIDTH{1'b0}}, mag_a};
              opnd     <= mag_b;
              neg_main <= req_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && (bus.b != '0);
              neg_rem  <= req_signed && bus.a[WIDTH-1];
            end else begin
              acc      <= {{WIDTH{1'b0}}, mag_b};
              opnd     <= mag_a;
              neg_main <= req_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem  <= 1'b0;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO and done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX) && !bus.cancel;
      if ((state == FIX) && !bus.cancel) begin
        if (is_div) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
      end else if (accept) begin
        if (bus.op == 3'b100) hi_q <= bus.a;
        if (bus.op == 3'b101) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
